// File: rtl/load_writeback_unit_pkg.sv
// Shared definitions for the load/writeback path: load encodings, FSM states
// and the alignment/legality rule for load commands.
package load_writeback_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  // A load is legal when funct3 is a known encoding and the address is
  // naturally aligned for its access size.
  function automatic logic load_legal(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_LB, F3_LBU: ok = 1'b1;
      F3_LH, F3_LHU: ok = ~off[0];
      F3_LW:         ok = (off == 2'b00);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_writeback_unit_load_extract.sv
// Combinational byte/halfword/word select with sign or zero extension,
// shared by the load writeback and store/forwarding paths.
module load_extract
  import load_writeback_unit_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (offset)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    result = '0;
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LW:   result = word;
      F3_LBU:  result = {24'd0, byte_sel};
      F3_LHU:  result = {16'd0, half_sel};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_writeback_unit.sv
// Multi-cycle load stage: issues a word read over req/ack, extends the
// addressed data and writes it to the register file for one cycle.
module load_writeback_unit
  import load_writeback_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            write_enable,
  output logic [4:0]      write_addr,
  output logic [XLEN-1:0] write_data
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [4:0]       rd_q;
  logic [XLEN-1:0]  ext_data;

  load_extract u_extract (
    .funct3 (f3_q),
    .offset (off_q),
    .word   (mem_rdata),
    .result (ext_data)
  );

  // Memory handshake: mem_req stays high from acceptance until the cycle
  // mem_ack is sampled or the timeout count is exhausted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      f3_q         <= '0;
      off_q        <= '0;
      rd_q         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else begin
      done         <= 1'b0;
      err          <= 1'b0;
      write_enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (load_legal(funct3, addr[1:0])) begin
              f3_q     <= funct3;
              off_q    <= addr[1:0];
              rd_q     <= rd;
              mem_addr <= {addr[XLEN-1:2], 2'b00};
              mem_req  <= 1'b1;
              busy     <= 1'b1;
              cnt      <= '0;
              state    <= S_REQ;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            // x0 is hardwired: skip the strobe and keep the last write values.
            if (rd_q != 5'd0) begin
              write_enable <= 1'b1;
              write_addr   <= rd_q;
              write_data   <= ext_data;
            end
            state <= S_WB;
          end else if (cnt == CNT_LAST) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WB: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          mem_req <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_writeback_unit.sv
// Directed bench for load_writeback_unit with a 4-cycle memory timeout.
module tb_load_writeback_unit;
  import load_writeback_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [4:0]  rd;
  logic        busy, done, err, mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;

  int checks = 0;
  int errors = 0;
  int we_count;

  load_writeback_unit #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .funct3       (funct3),
    .addr         (addr),
    .rd           (rd),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one load; ack is sampled k edges after acceptance (k >= 1).
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [4:0] r, input logic [31:0] data, input int k,
                          input logic [31:0] exp_data, input logic exp_we);
    @(negedge clk);
    start = 1'b1; funct3 = f3; addr = a; rd = r;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    check({tag, " mem_req"}, {31'd0, mem_req}, 32'd1);
    check({tag, " mem_addr"}, mem_addr, {a[31:2], 2'b00});
    for (int i = 1; i < k; i++) @(negedge clk);
    mem_ack = 1'b1; mem_rdata = data;
    @(negedge clk);
    mem_ack = 1'b0;
    check({tag, " we"}, {31'd0, write_enable}, {31'd0, exp_we});
    if (exp_we) begin
      check({tag, " waddr"}, {27'd0, write_addr}, {27'd0, r});
      check({tag, " wdata"}, write_data, exp_data);
    end
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " err"}, {31'd0, err}, 32'd0);
    check({tag, " req_low"}, {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    check({tag, " we_off"}, {31'd0, write_enable}, 32'd0);
    check({tag, " done_off"}, {31'd0, done}, 32'd0);
    check({tag, " busy_off"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_illegal(input string tag, input logic [2:0] f3, input logic [31:0] a);
    @(negedge clk);
    start = 1'b1; funct3 = f3; addr = a; rd = 5'd7;
    @(negedge clk);
    start = 1'b0;
    check({tag, " err"}, {31'd0, err}, 32'd1);
    check({tag, " mem_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, " busy"}, {31'd0, busy}, 32'd0);
    check({tag, " we"}, {31'd0, write_enable}, 32'd0);
    @(negedge clk);
    check({tag, " err_off"}, {31'd0, err}, 32'd0);
    check({tag, " mem_req2"}, {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; funct3 = 3'd0; addr = 32'd0; rd = 5'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst err", {31'd0, err}, 32'd0);
    check("rst mem_req", {31'd0, mem_req}, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst we", {31'd0, write_enable}, 32'd0);
    check("rst waddr", {27'd0, write_addr}, 32'd0);
    check("rst wdata", write_data, 32'd0);
    reset = 1'b0;

    run_load("lw", F3_LW, 32'h100, 5'd5, 32'hDEADBEEF, 3, 32'hDEADBEEF, 1'b1);
    run_load("lb", F3_LB, 32'h103, 5'd6, 32'h80112233, 1, 32'hFFFFFF80, 1'b1);
    run_load("lbu", F3_LBU, 32'h103, 5'd7, 32'h80112233, 2, 32'h00000080, 1'b1);
    run_load("lb1", F3_LB, 32'h101, 5'd8, 32'h80112233, 1, 32'h00000022, 1'b1);
    run_load("lh", F3_LH, 32'h102, 5'd9, 32'h80015555, 1, 32'hFFFF8001, 1'b1);
    run_load("lhu", F3_LHU, 32'h102, 5'd10, 32'h80015555, 2, 32'h00008001, 1'b1);
    run_load("lh0", F3_LH, 32'h200, 5'd11, 32'h1234F00D, 1, 32'hFFFFF00D, 1'b1);

    run_illegal("lh_mis", F3_LH, 32'h101);
    run_illegal("lw_mis", F3_LW, 32'h102);
    run_illegal("f3_011", 3'b011, 32'h100);

    // Timeout: four REQ cycles without ack, then abort with err.
    @(negedge clk);
    start = 1'b1; funct3 = F3_LW; addr = 32'h300; rd = 5'd12;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) check("to req_high", {31'd0, mem_req}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("to req_held", {31'd0, mem_req}, 32'd1);
    end
    @(negedge clk);
    check("to req_drop", {31'd0, mem_req}, 32'd0);
    check("to err", {31'd0, err}, 32'd1);
    check("to busy", {31'd0, busy}, 32'd0);
    check("to we", {31'd0, write_enable}, 32'd0);
    check("to done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("to err_off", {31'd0, err}, 32'd0);

    // Ack on the final allowed REQ cycle wins over the timeout.
    run_load("ack4", F3_LW, 32'h400, 5'd13, 32'hCAFEF00D, 4, 32'hCAFEF00D, 1'b1);

    // rd=0: done pulses, no strobe, write_data keeps the previous value.
    run_load("rd0", F3_LW, 32'h500, 5'd0, 32'h12345678, 2, 32'h0, 1'b0);
    check("rd0 wdata_hold", write_data, 32'hCAFEF00D);
    check("rd0 waddr_hold", {27'd0, write_addr}, 32'd13);

    // A start raised during REQ is ignored; exactly one write results.
    @(negedge clk);
    start = 1'b1; funct3 = F3_LW; addr = 32'h600; rd = 5'd14;
    @(negedge clk);
    funct3 = F3_LB; addr = 32'h700; rd = 5'd15;
    @(negedge clk);
    start = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
    we_count = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (write_enable) begin
        we_count++;
        check("dbl waddr", {27'd0, write_addr}, 32'd14);
        check("dbl wdata", write_data, 32'hA5A5A5A5);
      end
    end
    check("dbl we_count", we_count, 32'd1);
    check("dbl mem_req", {31'd0, mem_req}, 32'd0);

    // Asynchronous reset in REQ aborts the load immediately.
    @(negedge clk);
    start = 1'b1; funct3 = F3_LW; addr = 32'h800; rd = 5'd16;
    @(negedge clk);
    start = 1'b0;
    check("ar req_before", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("ar mem_req", {31'd0, mem_req}, 32'd0);
    check("ar busy", {31'd0, busy}, 32'd0);
    check("ar we", {31'd0, write_enable}, 32'd0);
    check("ar wdata", write_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    mem_ack = 1'b0;
    check("ar late_we", {31'd0, write_enable}, 32'd0);
    check("ar late_done", {31'd0, done}, 32'd0);
    check("ar late_err", {31'd0, err}, 32'd0);
    check("ar late_busy", {31'd0, busy}, 32'd0);

    run_load("post_rst", F3_LHU, 32'h902, 5'd17, 32'hBEEF0000, 1, 32'h0000BEEF, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
